alu_arbiter: RTL and testbench

Two-requester arbiter and two-stage issue/response pipeline that shares the single execute-stage ALU between the main pipeline (port 0) and a secondary multi-cycle unit (port 1). It grants at most one request per cycle (round-robin), registers the granted operands into an issue stage that drives the ALU, and captures the ALU result and flags into a response register with valid/ready backpressure. The ALU itself stays outside this block and connects through the alu_* ports.

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two requesters sharing one external ALU, followed by
// an issue register (drives the ALU) and a response register with valid/ready.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    output logic             gnt0,

    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             gnt1,

    output logic [WIDTH-1:0] alu_inA,
    output logic [WIDTH-1:0] alu_inB,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic             alu_cf,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    input  logic             rsp_ready
);

    typedef struct packed {
        logic             valid;
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
    } iss_t;

    typedef struct packed {
        logic             valid;
        logic             id;
        logic [WIDTH-1:0] data;
        logic [3:0]       flags;
    } rsp_t;

    iss_t iss_q;
    rsp_t rsp_q;
    logic last_id;

    logic rsp_move;
    logic iss_free;
    logic any_gnt;
    logic gnt_id;

    // Response register accepts the issue stage when it is empty or being drained;
    // the issue stage can take a new grant whenever its current entry moves on.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rsp_move = 1'b0;
        iss_free = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;

        rsp_move = iss_q.valid & (~rsp_q.valid | rsp_ready);
        iss_free = ~iss_q.valid | rsp_move;

        if (iss_free && !rst) begin
            gnt0 = req0 & (~req1 | last_id);
            gnt1 = req1 & (~req0 | ~last_id);
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign gnt_id  = gnt1;

    // Datapath registers are reset as well: the reset state of the ALU inputs
    // and response payload is observable at the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            iss_q   <= '0;
            rsp_q   <= '0;
            last_id <= 1'b1;
        end else begin
            if (any_gnt) begin
                iss_q.valid <= 1'b1;
                iss_q.id    <= gnt_id;
                iss_q.a     <= gnt_id ? a1  : a0;
                iss_q.b     <= gnt_id ? b1  : b0;
                iss_q.op    <= gnt_id ? op1 : op0;
                last_id     <= gnt_id;
            end else if (rsp_move) begin
                iss_q.valid <= 1'b0;
            end

            if (rsp_move) begin
                rsp_q.valid <= 1'b1;
                rsp_q.id    <= iss_q.id;
                rsp_q.data  <= alu_out;
                rsp_q.flags <= {alu_zf, alu_sf, alu_of, alu_cf};
            end else if (rsp_ready) begin
                rsp_q.valid <= 1'b0;
            end
        end
    end

    assign alu_inA   = iss_q.a;
    assign alu_inB   = iss_q.b;
    assign alu_op    = iss_q.op;

    assign rsp_valid = rsp_q.valid;
    assign rsp_id    = rsp_q.id;
    assign rsp_data  = rsp_q.data;
    assign rsp_flags = rsp_q.flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU closing the loop on alu_* ports.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;
    localparam logic [OPW-1:0] OP_ADD = 4'h0;
    localparam logic [OPW-1:0] OP_SUB = 4'h1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [OPW-1:0]   op0, op1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] alu_inA, alu_inB, alu_out;
    logic [OPW-1:0]   alu_op;
    logic             alu_zf, alu_sf, alu_of, alu_cf;
    logic             rsp_valid, rsp_id, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;
    logic [WIDTH:0]   alu_wide;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_op(alu_op), .alu_out(alu_out),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .alu_cf(alu_cf),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_ready(rsp_ready)
    );

    // Reference ALU: ADD/SUB with carry (borrow for SUB) and signed overflow.
    always_comb begin
        alu_wide = '0;
        if (alu_op == OP_SUB) alu_wide = {1'b0, alu_inA} - {1'b0, alu_inB};
        else                  alu_wide = {1'b0, alu_inA} + {1'b0, alu_inB};
        alu_out = alu_wide[WIDTH-1:0];
        alu_cf  = alu_wide[WIDTH];
        alu_zf  = (alu_out == '0);
        alu_sf  = alu_out[WIDTH-1];
        if (alu_op == OP_SUB)
            alu_of = (alu_inA[WIDTH-1] != alu_inB[WIDTH-1]) && (alu_out[WIDTH-1] != alu_inA[WIDTH-1]);
        else
            alu_of = (alu_inA[WIDTH-1] == alu_inB[WIDTH-1]) && (alu_out[WIDTH-1] != alu_inA[WIDTH-1]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backpressure stream on port 1, rsp_ready low in cycles 3..6.
    logic             bp_gnt  [11] = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    logic             bp_rv   [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [WIDTH-1:0] bp_data [11] = '{16'h0, 16'h0, 16'h1001, 16'h1002, 16'h1002, 16'h1002,
                                       16'h1002, 16'h1002, 16'h1003, 16'h1004, 16'h0};

    initial begin
        int n;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = OP_ADD; op1 = OP_ADD;

        // Reset: grants forced low even with both requests high.
        tick();
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        tick();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data",  rsp_data, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_id",    rsp_id, 0);
        check("rst_alu_inA",   alu_inA, 0);
        check("rst_alu_op",    alu_op, 0);

        // Single op: 5 + 3, grant cycle 0, response cycle 2.
        tick();
        req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0003; op0 = OP_ADD;
        #1;
        check("single_gnt0", gnt0, 1);
        check("single_gnt1", gnt1, 0);
        tick();
        req0 = 1'b0;
        #1;
        check("single_inA", alu_inA, 16'h0005);
        check("single_inB", alu_inB, 16'h0003);
        check("single_op",  alu_op, OP_ADD);
        check("single_rv_c1", rsp_valid, 0);
        tick();
        #1;
        check("single_rv_c2", rsp_valid, 1);
        check("single_data",  rsp_data, 16'h0008);
        check("single_id",    rsp_id, 0);
        check("single_flags", rsp_flags, 4'b0000);
        tick();
        #1;
        check("single_rv_c3", rsp_valid, 0);

        // Flags, back-to-back on port 1.
        tick();
        req1 = 1'b1; a1 = 16'h7FFF; b1 = 16'h0001; op1 = OP_ADD;
        #1;
        check("flags_gnt1_a", gnt1, 1);
        tick();
        a1 = 16'h0001; b1 = 16'hFFFF;
        #1;
        check("flags_gnt1_b", gnt1, 1);
        tick();
        req1 = 1'b0;
        #1;
        check("flags_ovf_rv",    rsp_valid, 1);
        check("flags_ovf_data",  rsp_data, 16'h8000);
        check("flags_ovf_flags", rsp_flags, 4'b0110);
        check("flags_ovf_id",    rsp_id, 1);
        tick();
        #1;
        check("flags_zc_rv",    rsp_valid, 1);
        check("flags_zc_data",  rsp_data, 16'h0000);
        check("flags_zc_flags", rsp_flags, 4'b1001);

        // Reset mid-operation: grant in cycle 0, rst in cycle 1.
        tick();
        req0 = 1'b1; a0 = 16'h0042; b0 = 16'h0001; op0 = OP_ADD;
        #1;
        check("midrst_gnt0", gnt0, 1);
        tick();
        req0 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_rv_c2",  rsp_valid, 0);
        check("midrst_inA",    alu_inA, 0);
        check("midrst_op",     alu_op, 0);
        check("midrst_data",   rsp_data, 0);
        check("midrst_id",     rsp_id, 0);
        check("midrst_flags",  rsp_flags, 0);
        tick();
        #1;
        check("midrst_rv_c3", rsp_valid, 0);

        // Tie after reset: grants 0,1,0,1; responses in the same order from cycle 2.
        a0 = 16'h0100; b0 = 16'h0020; op0 = OP_ADD;
        a1 = 16'h0200; b1 = 16'h0003; op1 = OP_SUB;
        for (int k = 0; k < 7; k++) begin
            tick();
            req0 = (k < 4); req1 = (k < 4);
            #1;
            check($sformatf("tie_gnt0_%0d", k), gnt0, (k < 4) && (k % 2 == 0));
            check($sformatf("tie_gnt1_%0d", k), gnt1, (k < 4) && (k % 2 == 1));
            check($sformatf("tie_rv_%0d", k), rsp_valid, (k >= 2) && (k < 6));
            if (k >= 2 && k < 6) begin
                check($sformatf("tie_id_%0d", k), rsp_id, (k - 2) % 2);
                check($sformatf("tie_data_%0d", k), rsp_data, ((k - 2) % 2 == 0) ? 16'h0120 : 16'h01FD);
            end
        end

        // Backpressure on a port-1 stream.
        n = 0;
        for (int k = 0; k < 11; k++) begin
            tick();
            req1 = (k <= 7);
            rsp_ready = !(k >= 3 && k <= 6);
            a1 = 16'h1000 + 16'(n); b1 = 16'h0001; op1 = OP_ADD;
            #1;
            check($sformatf("bp_gnt1_%0d", k), gnt1, bp_gnt[k]);
            check($sformatf("bp_rv_%0d", k), rsp_valid, bp_rv[k]);
            if (bp_rv[k]) begin
                check($sformatf("bp_data_%0d", k), rsp_data, bp_data[k]);
                check($sformatf("bp_id_%0d", k), rsp_id, 1);
            end
            if (bp_gnt[k]) n++;
        end
        rsp_ready = 1'b1;

        // Port-0 streaming, then a tie must go to port 1 (last winner was 0).
        a1 = 16'h0030; b1 = 16'h0005; op1 = OP_SUB;
        for (int k = 0; k < 10; k++) begin
            tick();
            req0 = (k <= 6); req1 = (k == 6);
            a0 = 16'(k + 1); b0 = 16'(k + 1); op0 = OP_ADD;
            #1;
            check($sformatf("strm_gnt0_%0d", k), gnt0, k < 6);
            check($sformatf("strm_gnt1_%0d", k), gnt1, k == 6);
            check($sformatf("strm_rv_%0d", k), rsp_valid, (k >= 2) && (k <= 8));
            if (k >= 2 && k <= 7) begin
                check($sformatf("strm_data_%0d", k), rsp_data, 16'(2 * (k - 1)));
                check($sformatf("strm_id_%0d", k), rsp_id, 0);
            end
            if (k == 8) begin
                check("strm_tie_data", rsp_data, 16'h002B);
                check("strm_tie_id", rsp_id, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
